// File: rtl/alu_ctrl_pipe_pkg.sv
// Shared constants for the ALU-control decoder: MIPS op/funct fields, EXE_*_OP codes,
// and the combinational decode function used by the registered stage.
package alu_ctrl_pipe_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010, F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100, F_SRLV = 6'b000110, F_SRAV  = 6'b000111;
  localparam logic [5:0] F_JR   = 6'b001000, F_JALR = 6'b001001;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD  = 6'b100000, F_ADDU = 6'b100001, F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011, F_AND  = 6'b100100, F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110, F_NOR  = 6'b100111, F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  localparam logic [5:0] OP_J    = 6'b000010, OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100, OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110, OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB   = 6'b100000, OP_LH    = 6'b100001, OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU  = 6'b100100, OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB   = 6'b101000, OP_SH    = 6'b101001, OP_SW  = 6'b101011;

  localparam logic [7:0] EXE_AND_OP  = 8'h24, EXE_OR_OP   = 8'h25, EXE_XOR_OP  = 8'h26;
  localparam logic [7:0] EXE_NOR_OP  = 8'h27, EXE_SLT_OP  = 8'h2A, EXE_SLTU_OP = 8'h2B;
  localparam logic [7:0] EXE_ADD_OP  = 8'h20, EXE_ADDU_OP = 8'h21, EXE_SUB_OP  = 8'h22;
  localparam logic [7:0] EXE_SUBU_OP = 8'h23, EXE_SLL_OP  = 8'h7C, EXE_SRL_OP  = 8'h02;
  localparam logic [7:0] EXE_SRA_OP  = 8'h03, EXE_SLLV_OP = 8'h04, EXE_SRLV_OP = 8'h06;
  localparam logic [7:0] EXE_SRAV_OP = 8'h07, EXE_MULT_OP = 8'h18, EXE_MULTU_OP = 8'h19;
  localparam logic [7:0] EXE_DIV_OP  = 8'h1A, EXE_DIVU_OP = 8'h1B;
  localparam logic [7:0] EXE_JR_OP   = 8'h08, EXE_JALR_OP = 8'h09;
  localparam logic [7:0] EXE_ANDI_OP = 8'h59, EXE_ORI_OP  = 8'h5A, EXE_XORI_OP = 8'h5B;
  localparam logic [7:0] EXE_LUI_OP  = 8'h5C, EXE_ADDI_OP = 8'h55, EXE_ADDIU_OP = 8'h56;
  localparam logic [7:0] EXE_SLTI_OP = 8'h57, EXE_SLTIU_OP = 8'h58;
  localparam logic [7:0] EXE_LB_OP   = 8'hE0, EXE_LBU_OP  = 8'hE4, EXE_LH_OP   = 8'hE1;
  localparam logic [7:0] EXE_LHU_OP  = 8'hE5, EXE_LW_OP   = 8'hE3, EXE_SB_OP   = 8'hE8;
  localparam logic [7:0] EXE_SH_OP   = 8'hE9, EXE_SW_OP   = 8'hEB;
  localparam logic [7:0] EXE_J_OP    = 8'h4F, EXE_JAL_OP  = 8'h50;
  localparam logic [7:0] EXE_BEQ_OP  = 8'h51, EXE_BNE_OP  = 8'h52;

  typedef struct packed {
    logic [7:0] ctrl;
    logic       muldiv;
    logic       is_div;
    logic       ri;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct);
    dec_t d;
    d = '{ctrl: EXE_ADDU_OP, muldiv: 1'b0, is_div: 1'b0, ri: 1'b0};
    if (op == OP_SPECIAL) begin
      case (funct)
        F_AND:   d.ctrl = EXE_AND_OP;
        F_OR:    d.ctrl = EXE_OR_OP;
        F_XOR:   d.ctrl = EXE_XOR_OP;
        F_NOR:   d.ctrl = EXE_NOR_OP;
        F_SLT:   d.ctrl = EXE_SLT_OP;
        F_SLTU:  d.ctrl = EXE_SLTU_OP;
        F_ADD:   d.ctrl = EXE_ADD_OP;
        F_ADDU:  d.ctrl = EXE_ADDU_OP;
        F_SUB:   d.ctrl = EXE_SUB_OP;
        F_SUBU:  d.ctrl = EXE_SUBU_OP;
        F_SLL:   d.ctrl = EXE_SLL_OP;
        F_SRL:   d.ctrl = EXE_SRL_OP;
        F_SRA:   d.ctrl = EXE_SRA_OP;
        F_SLLV:  d.ctrl = EXE_SLLV_OP;
        F_SRLV:  d.ctrl = EXE_SRLV_OP;
        F_SRAV:  d.ctrl = EXE_SRAV_OP;
        F_JR:    d.ctrl = EXE_JR_OP;
        F_JALR:  d.ctrl = EXE_JALR_OP;
        F_MULT:  begin d.ctrl = EXE_MULT_OP;  d.muldiv = 1'b1; end
        F_MULTU: begin d.ctrl = EXE_MULTU_OP; d.muldiv = 1'b1; end
        F_DIV:   begin d.ctrl = EXE_DIV_OP;   d.muldiv = 1'b1; d.is_div = 1'b1; end
        F_DIVU:  begin d.ctrl = EXE_DIVU_OP;  d.muldiv = 1'b1; d.is_div = 1'b1; end
        default: d.ri = 1'b1;
      endcase
    end else begin
      case (op)
        OP_ANDI:  d.ctrl = EXE_ANDI_OP;
        OP_ORI:   d.ctrl = EXE_ORI_OP;
        OP_XORI:  d.ctrl = EXE_XORI_OP;
        OP_LUI:   d.ctrl = EXE_LUI_OP;
        OP_ADDI:  d.ctrl = EXE_ADDI_OP;
        OP_ADDIU: d.ctrl = EXE_ADDIU_OP;
        OP_SLTI:  d.ctrl = EXE_SLTI_OP;
        OP_SLTIU: d.ctrl = EXE_SLTIU_OP;
        OP_LB:    d.ctrl = EXE_LB_OP;
        OP_LBU:   d.ctrl = EXE_LBU_OP;
        OP_LH:    d.ctrl = EXE_LH_OP;
        OP_LHU:   d.ctrl = EXE_LHU_OP;
        OP_LW:    d.ctrl = EXE_LW_OP;
        OP_SB:    d.ctrl = EXE_SB_OP;
        OP_SH:    d.ctrl = EXE_SH_OP;
        OP_SW:    d.ctrl = EXE_SW_OP;
        OP_J:     d.ctrl = EXE_J_OP;
        OP_JAL:   d.ctrl = EXE_JAL_OP;
        OP_BEQ:   d.ctrl = EXE_BEQ_OP;
        OP_BNE:   d.ctrl = EXE_BNE_OP;
        default:  d.ri = 1'b1;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_pipe_md.sv
// Mult/div occupancy counter: loaded on accept, counts down on unstalled cycles,
// and pulses done for one cycle when it reaches zero.
module md_occupancy_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             hold,
  input  logic             clr,
  output logic             busy,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  assign busy = (cnt != '0);

  // done is cleared while held so a stall can never stretch the pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (hold) begin
      done <= 1'b0;
    end else begin
      done <= (cnt == CNT_W'(1));
      if (load)         cnt <= load_val;
      else if (busy)    cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU-control decoder at the decode->execute boundary with valid/ready
// handshake, stall/flush, and mult/div occupancy sequencing.
module alu_ctrl_pipe
  import alu_ctrl_pipe_pkg::*;
#(
  parameter int CTRL_W     = 8,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [CTRL_W-1:0] alucontrol,
  output logic              is_muldiv,
  output logic              ri_exc,
  output logic              md_busy,
  output logic              md_done
);

  dec_t dec;
  logic accept;

  always_comb dec = decode(op, funct);

  assign in_ready = !stall && !flush && !md_busy;
  assign accept   = in_valid && in_ready;

  // alucontrol keeps its last value on flush/idle; only the qualifiers are cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alucontrol <= CTRL_W'(EXE_ADDU_OP);
      is_muldiv  <= 1'b0;
      ri_exc     <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      is_muldiv  <= 1'b0;
      ri_exc     <= 1'b0;
    end else if (!stall) begin
      if (accept) begin
        out_valid  <= 1'b1;
        alucontrol <= CTRL_W'(dec.ctrl);
        is_muldiv  <= dec.muldiv;
        ri_exc     <= dec.ri;
      end else begin
        out_valid  <= 1'b0;
      end
    end
  end

  md_occupancy_cnt #(.CNT_W(CNT_W)) u_md_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && dec.muldiv),
    .load_val (dec.is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES)),
    .hold     (stall),
    .clr      (flush),
    .busy     (md_busy),
    .done     (md_done)
  );

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe: directed scenarios plus randomized traffic
// checked against a cycle-level reference model built from decode tables.
module tb_alu_ctrl_pipe;

  localparam int MULC = 2;
  localparam int DIVC = 4;

  logic clk = 0, rst = 0, in_valid = 0, stall = 0, flush = 0;
  logic [5:0] op = '0, funct = '0;
  logic in_ready, out_valid, is_muldiv, ri_exc, md_busy, md_done;
  logic [7:0] alucontrol;

  alu_ctrl_pipe #(.CTRL_W(8), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .funct(funct),
    .stall(stall), .flush(flush), .out_valid(out_valid), .alucontrol(alucontrol),
    .is_muldiv(is_muldiv), .ri_exc(ri_exc), .md_busy(md_busy), .md_done(md_done));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int rt_code[int];
  int it_code[int];
  logic [5:0] vops[20] = '{6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h20, 6'h24,
                           6'h21, 6'h25, 6'h23, 6'h28, 6'h29, 6'h2B, 6'h02, 6'h03, 6'h04, 6'h05};
  logic [5:0] vfn[22] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h20, 6'h21, 6'h22, 6'h23, 6'h00,
                          6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h08, 6'h09};

  // reference model state
  logic       m_v, m_md, m_ri, m_done;
  logic [7:0] m_ctrl;
  int         m_cnt;

  task automatic init_tables();
    rt_code[6'h24] = 8'h24; rt_code[6'h25] = 8'h25; rt_code[6'h26] = 8'h26; rt_code[6'h27] = 8'h27;
    rt_code[6'h2A] = 8'h2A; rt_code[6'h2B] = 8'h2B; rt_code[6'h20] = 8'h20; rt_code[6'h21] = 8'h21;
    rt_code[6'h22] = 8'h22; rt_code[6'h23] = 8'h23; rt_code[6'h00] = 8'h7C; rt_code[6'h02] = 8'h02;
    rt_code[6'h03] = 8'h03; rt_code[6'h04] = 8'h04; rt_code[6'h06] = 8'h06; rt_code[6'h07] = 8'h07;
    rt_code[6'h18] = 8'h18; rt_code[6'h19] = 8'h19; rt_code[6'h1A] = 8'h1A; rt_code[6'h1B] = 8'h1B;
    rt_code[6'h08] = 8'h08; rt_code[6'h09] = 8'h09;
    it_code[6'h0C] = 8'h59; it_code[6'h0D] = 8'h5A; it_code[6'h0E] = 8'h5B; it_code[6'h0F] = 8'h5C;
    it_code[6'h08] = 8'h55; it_code[6'h09] = 8'h56; it_code[6'h0A] = 8'h57; it_code[6'h0B] = 8'h58;
    it_code[6'h20] = 8'hE0; it_code[6'h24] = 8'hE4; it_code[6'h21] = 8'hE1; it_code[6'h25] = 8'hE5;
    it_code[6'h23] = 8'hE3; it_code[6'h28] = 8'hE8; it_code[6'h29] = 8'hE9; it_code[6'h2B] = 8'hEB;
    it_code[6'h02] = 8'h4F; it_code[6'h03] = 8'h50; it_code[6'h04] = 8'h51; it_code[6'h05] = 8'h52;
  endtask

  function automatic void ref_decode(input logic [5:0] o, input logic [5:0] f, output logic [7:0] c,
                                     output logic md, output logic ri, output int cyc);
    c = 8'h21; md = 0; ri = 0; cyc = 0;
    if (o == 6'd0) begin
      if (rt_code.exists(int'(f))) begin
        c = 8'(rt_code[int'(f)]);
        if (f >= 6'h18 && f <= 6'h1B) begin
          md = 1;
          cyc = (f >= 6'h1A) ? DIVC : MULC;
        end
      end else ri = 1;
    end else if (it_code.exists(int'(o))) c = 8'(it_code[int'(o)]);
    else ri = 1;
  endfunction

  task automatic model_reset();
    m_v = 0; m_md = 0; m_ri = 0; m_done = 0; m_ctrl = 8'h21; m_cnt = 0;
  endtask

  function automatic logic exp_ready();
    return !stall && !flush && (m_cnt == 0);
  endfunction

  task automatic drive(input logic iv, input logic [5:0] o, input logic [5:0] f,
                       input logic st, input logic fl);
    in_valid = iv; op = o; funct = f; stall = st; flush = fl;
    #1;
  endtask

  // advance one clock and update the model from the inputs held across the edge
  task automatic edge_step();
    logic [7:0] c; logic md, ri, acc; int cyc;
    ref_decode(op, funct, c, md, ri, cyc);
    acc = in_valid && exp_ready();
    @(posedge clk);
    if (flush) begin
      m_v = 0; m_ri = 0; m_md = 0; m_cnt = 0; m_done = 0;
    end else if (stall) begin
      m_done = 0;
    end else begin
      m_done = (m_cnt == 1);
      if (m_cnt > 0) m_cnt--;
      if (acc) begin
        m_v = 1; m_ctrl = c; m_md = md; m_ri = ri;
        if (md) m_cnt = cyc;
      end else m_v = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (alucontrol !== 8'h21) begin n_err++; $display("FAIL reset_alucontrol got %h want 21", alucontrol); end
    n_cmp++; if ({is_muldiv, ri_exc, md_busy, md_done} !== 4'b0) begin n_err++;
      $display("FAIL reset_flags got %b want 0000", {is_muldiv, ri_exc, md_busy, md_done}); end
    @(negedge clk) rst = 0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_and();
    drive(1, 6'h00, 6'h24, 0, 0);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL and_in_ready got %b want 1", in_ready); end
    edge_step();
    n_cmp++; if (out_valid !== 1'b1 || alucontrol !== 8'h24 || ri_exc !== 1'b0) begin n_err++;
      $display("FAIL and_decode got v=%b ctrl=%h ri=%b want v=1 ctrl=24 ri=0", out_valid, alucontrol, ri_exc); end
  endtask

  task automatic test_reserved();
    drive(1, 6'h3F, 6'($urandom), 0, 0);
    edge_step();
    n_cmp++; if (out_valid !== 1'b1 || ri_exc !== 1'b1 || alucontrol !== 8'h21) begin n_err++;
      $display("FAIL ri_decode got v=%b ri=%b ctrl=%h want v=1 ri=1 ctrl=21", out_valid, ri_exc, alucontrol); end
    drive(0, 6'h00, 6'h00, 0, 0);
    edge_step();
    n_cmp++; if (out_valid !== 1'b0 || ri_exc !== 1'b1) begin n_err++;
      $display("FAIL ri_idle got v=%b ri=%b want v=0 ri=1", out_valid, ri_exc); end
  endtask

  task automatic test_div_occupancy();
    drive(1, 6'h00, 6'h1A, 0, 0);
    edge_step();
    n_cmp++; if (alucontrol !== 8'h1A || is_muldiv !== 1'b1) begin n_err++;
      $display("FAIL div_decode got ctrl=%h md=%b want ctrl=1a md=1", alucontrol, is_muldiv); end
    for (int k = 0; k < DIVC; k++) begin
      drive(1, 6'h00, 6'h20, 0, 0);
      n_cmp++; if (md_busy !== 1'b1 || in_ready !== 1'b0 || md_done !== 1'b0) begin n_err++;
        $display("FAIL div_busy[%0d] got busy=%b rdy=%b done=%b want 1 0 0", k, md_busy, in_ready, md_done); end
      edge_step();
    end
    n_cmp++; if (md_busy !== 1'b0 || md_done !== 1'b1 || in_ready !== 1'b1) begin n_err++;
      $display("FAIL div_done got busy=%b done=%b rdy=%b want 0 1 1", md_busy, md_done, in_ready); end
    edge_step();
    n_cmp++; if (md_done !== 1'b0 || out_valid !== 1'b1 || alucontrol !== 8'h20) begin n_err++;
      $display("FAIL div_after got done=%b v=%b ctrl=%h want 0 1 20", md_done, out_valid, alucontrol); end
    drive(0, 6'h00, 6'h00, 0, 0);
    edge_step();
  endtask

  task automatic test_mult_stall();
    int done_at;
    done_at = -1;
    drive(1, 6'h00, 6'h18, 0, 0);
    edge_step();
    for (int k = 0; k < 3; k++) begin
      drive(1, 6'h08, 6'h00, 1, 0);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d] got %b want 0", k, in_ready); end
      edge_step();
      n_cmp++; if (out_valid !== 1'b1 || alucontrol !== 8'h18 || is_muldiv !== 1'b1 || md_busy !== 1'b1 || md_done !== 1'b0) begin
        n_err++; $display("FAIL stall_hold[%0d] got v=%b ctrl=%h md=%b busy=%b done=%b want 1 18 1 1 0",
                          k, out_valid, alucontrol, is_muldiv, md_busy, md_done); end
    end
    for (int k = 1; k <= 4; k++) begin
      drive(0, 6'h00, 6'h00, 0, 0);
      edge_step();
      if (md_done === 1'b1 && done_at < 0) done_at = k;
    end
    n_cmp++; if (done_at !== MULC) begin n_err++;
      $display("FAIL stall_done_cycle got %0d want %0d", done_at, MULC); end
  endtask

  task automatic test_flush();
    int pulses;
    pulses = 0;
    drive(1, 6'h00, 6'h1B, 0, 0);
    edge_step();
    drive(0, 6'h00, 6'h00, 0, 0);
    edge_step();
    drive(1, 6'h08, 6'h00, 0, 1);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    edge_step();
    n_cmp++; if (md_busy !== 1'b0 || out_valid !== 1'b0 || is_muldiv !== 1'b0 || ri_exc !== 1'b0) begin n_err++;
      $display("FAIL flush_clear got busy=%b v=%b md=%b ri=%b want 0000", md_busy, out_valid, is_muldiv, ri_exc); end
    for (int k = 0; k < DIVC + 2; k++) begin
      drive(0, 6'h00, 6'h00, 0, 0);
      edge_step();
      if (md_done !== 1'b0) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL flush_no_done got %0d pulses want 0", pulses); end
  endtask

  task automatic test_async_reset();
    drive(1, 6'h00, 6'h1A, 0, 0);
    edge_step();
    drive(0, 6'h00, 6'h00, 0, 0);
    edge_step();
    #2 rst = 1;
    #1;
    n_cmp++; if ({out_valid, is_muldiv, ri_exc, md_busy, md_done} !== 5'b0 || alucontrol !== 8'h21) begin n_err++;
      $display("FAIL async_reset got v=%b md=%b ri=%b busy=%b done=%b ctrl=%h want 00000 21",
               out_valid, is_muldiv, ri_exc, md_busy, md_done, alucontrol); end
    @(negedge clk) rst = 0;
    model_reset();
    @(posedge clk); #1;
    drive(1, 6'h08, 6'($urandom), 0, 0);
    edge_step();
    n_cmp++; if (out_valid !== 1'b1 || alucontrol !== 8'h55 || ri_exc !== 1'b0 || md_done !== 1'b0) begin n_err++;
      $display("FAIL post_reset_addi got v=%b ctrl=%h ri=%b done=%b want 1 55 0 0", out_valid, alucontrol, ri_exc, md_done); end
  endtask

  task automatic test_random();
    logic [5:0] o, f;
    for (int i = 0; i < 400; i++) begin
      case ($urandom % 4)
        0, 1:    o = 6'h00;
        2:       o = vops[$urandom % 20];
        default: o = 6'($urandom);
      endcase
      f = ($urandom % 4 != 0) ? vfn[$urandom % 22] : 6'($urandom);
      drive(($urandom % 10) < 7, o, f, ($urandom % 100) < 15, ($urandom % 100) < 5);
      n_cmp++; if (in_ready !== exp_ready()) begin n_err++;
        $display("FAIL rnd_in_ready[%0d] got %b want %b", i, in_ready, exp_ready()); end
      edge_step();
      n_cmp++;
      if (out_valid !== m_v || alucontrol !== m_ctrl || is_muldiv !== m_md || ri_exc !== m_ri ||
          md_busy !== (m_cnt != 0) || md_done !== m_done) begin
        n_err++;
        $display("FAIL rnd_outputs[%0d] got v=%b ctrl=%h md=%b ri=%b busy=%b done=%b want v=%b ctrl=%h md=%b ri=%b busy=%b done=%b",
                 i, out_valid, alucontrol, is_muldiv, ri_exc, md_busy, md_done,
                 m_v, m_ctrl, m_md, m_ri, (m_cnt != 0), m_done);
      end
    end
    drive(0, 6'h00, 6'h00, 0, 0);
  endtask

  initial begin
    init_tables();
    model_reset();
    test_reset();
    test_and();
    test_reserved();
    test_div_occupancy();
    test_mult_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
